// File: rtl/btn_pulse_pkg.sv
// Shared state encodings and counter sizing for the push-button pulse generator.
package btn_pulse_pkg;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
   localparam logic [1:0] ST_HELD      = 2'd2;
   localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

   typedef enum logic [1:0] {
      IDLE      = ST_IDLE,
      WAIT_HIGH = ST_WAIT_HIGH,
      HELD      = ST_HELD,
      WAIT_LOW  = ST_WAIT_LOW
   } state_t;

   // One spare bit so a terminal count of n-1 always fits, even for n = 1.
   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops clear on reset.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   // NOTE: non-blocking assignments keep both flops sampling the same edge;
   // blocking here would collapse the chain into a single flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/btn_pulse.sv
// Debounced push-button press strobe and level. Define BTN_PULSE_AUTOREPEAT_EN to add
// hold-to-repeat pulses; the default build emits exactly one pulse per press.
module btn_pulse
   import btn_pulse_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 500000,
   parameter int REPEAT_PERIOD   = 100000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic pulse,
   output logic pressed
);

   localparam int DW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
      $error("btn_pulse: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
   end

   state_t          state, state_n;
   logic [DW-1:0]   dcnt, dcnt_n;
   logic            pulse_n;
   logic            sync;
   logic            rfire;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (btn_in),
      .q     (sync)
   );

`ifdef BTN_PULSE_AUTOREPEAT_EN
   localparam int RW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

   logic [RW-1:0] rcnt, rcnt_n;
   logic          rphase, rphase_n;   // 0: waiting for first repeat, 1: periodic repeats

   // Counter runs only while held with the button down; any other condition zeroes it,
   // so every entry into HELD starts the delay afresh.
   always_comb begin
      rcnt_n   = '0;
      rphase_n = 1'b0;
      rfire    = 1'b0;
      if (state == HELD && sync) begin
         rfire = rphase ? (rcnt == RW'(REPEAT_PERIOD - 1))
                        : (rcnt == RW'(REPEAT_DELAY - 1));
         if (rfire) begin
            rphase_n = 1'b1;
         end else begin
            rcnt_n   = rcnt + RW'(1);
            rphase_n = rphase;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rcnt   <= '0;
         rphase <= 1'b0;
      end else begin
         rcnt   <= rcnt_n;
         rphase <= rphase_n;
      end
   end
`else
   assign rfire = 1'b0;
`endif

   // NOTE: every output of this block gets a default first, so no path leaves a
   // variable unassigned and no latch is inferred.
   always_comb begin
      state_n = state;
      dcnt_n  = dcnt;
      pulse_n = rfire;
      case (state)
         IDLE: begin
            if (sync) begin
               state_n = WAIT_HIGH;
               dcnt_n  = '0;
            end
         end
         WAIT_HIGH: begin
            if (!sync) begin
               state_n = IDLE;
            end else if (dcnt == DMAX) begin
               state_n = HELD;
               pulse_n = 1'b1;
            end else begin
               dcnt_n = dcnt + DW'(1);
            end
         end
         HELD: begin
            if (!sync) begin
               state_n = WAIT_LOW;
               dcnt_n  = '0;
            end
         end
         WAIT_LOW: begin
            if (sync) begin
               state_n = HELD;
            end else if (dcnt == DMAX) begin
               state_n = IDLE;
            end else begin
               dcnt_n = dcnt + DW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         dcnt    <= '0;
         pulse   <= 1'b0;
         pressed <= 1'b0;
      end else begin
         state   <= state_n;
         dcnt    <= dcnt_n;
         pulse   <= pulse_n;
         pressed <= (state_n == HELD) || (state_n == WAIT_LOW);
      end
   end

endmodule

// File: tb/tb_btn_pulse.sv
// Directed bench for btn_pulse with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
// Bit i of a captured mask holds the signal in cycle i+1 after the first driven edge.
module tb_btn_pulse;

   logic clk = 1'b0;
   logic reset;
   logic btn_in;
   logic pulse;
   logic pressed;

   int checks = 0;
   int errors = 0;

   // Downstream press counter: one out strobe per five w pulses.
   int pulse_total = 0;
   int out_total   = 0;
   int press_cnt   = 0;

   logic [31:0] pm, qm;

   btn_pulse #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (8),
      .REPEAT_PERIOD   (3)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .btn_in  (btn_in),
      .pulse   (pulse),
      .pressed (pressed)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive btn_in = b for n cycles, sampling outputs 1 time unit after each rising edge.
   task automatic run(input int n, input logic b, output logic [31:0] p, output logic [31:0] q);
      p = '0;
      q = '0;
      btn_in = b;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         p[i] = pulse;
         q[i] = pressed;
         if (pulse === 1'b1) begin
            pulse_total++;
            if (press_cnt == 4) begin
               press_cnt = 0;
               out_total++;
            end else begin
               press_cnt++;
            end
         end
      end
   endtask

   initial begin
      int base;
      reset  = 1'b1;
      btn_in = 1'b0;
      run(3, 1'b0, pm, qm);
      check("reset_pulse", {31'b0, pulse}, 32'h0);
      check("reset_pressed", {31'b0, pressed}, 32'h0);
      reset = 1'b0;
      run(4, 1'b0, pm, qm);

      // Clean press held 20 cycles, then release
      run(20, 1'b1, pm, qm);
`ifdef BTN_PULSE_AUTOREPEAT_EN
      check("clean_pulse", pm, 32'h0002_4040);
`else
      check("clean_pulse", pm, 32'h0000_0040);
`endif
      check("clean_pressed", qm, 32'h000F_FFC0);
      run(10, 1'b0, pm, qm);
      check("release_pulse", pm, 32'h0);
      check("release_pressed", qm, 32'h0000_003F);

      // Bounce 1,1,0,1 then steady high: pulse 7 cycles after edge 4
      run(2, 1'b1, pm, qm);
      check("bounce_early", pm | qm, 32'h0);
      run(1, 1'b0, pm, qm);
      run(13, 1'b1, pm, qm);
      check("bounce_pulse", pm, 32'h0000_0040);
      run(12, 1'b0, pm, qm);
      check("bounce_release", {31'b0, pressed}, 32'h0);

      // Release glitch inside HELD
      run(10, 1'b1, pm, qm);
      check("glitch_hold_pressed", qm, 32'h0000_03C0);
      run(2, 1'b0, pm, qm);
      check("glitch_low_pulse", pm, 32'h0);
      check("glitch_low_pressed", qm, 32'h0000_0003);
      run(10, 1'b1, pm, qm);
      check("glitch_back_pulse", pm, 32'h0);
      check("glitch_back_pressed", qm, 32'h0000_03FF);
      run(12, 1'b0, pm, qm);
      check("glitch_release", {31'b0, pressed}, 32'h0);

      // Reset in the middle of WAIT_HIGH with the button held
      run(4, 1'b1, pm, qm);
      check("midrst_pre", pm | qm, 32'h0);
      reset = 1'b1;
      run(2, 1'b1, pm, qm);
      check("midrst_during", pm | qm, 32'h0);
      reset = 1'b0;
      run(16, 1'b1, pm, qm);
`ifdef BTN_PULSE_AUTOREPEAT_EN
      check("midrst_pulse", pm, 32'h0000_4040);
`else
      check("midrst_pulse", pm, 32'h0000_0040);
`endif
      check("midrst_pressed", qm, 32'h0000_FFC0);
      run(12, 1'b0, pm, qm);

      // Long hold of 30 cycles
      run(30, 1'b1, pm, qm);
`ifdef BTN_PULSE_AUTOREPEAT_EN
      check("hold30_pulse", pm, 32'h2492_4040);
`else
      check("hold30_pulse", pm, 32'h0000_0040);
`endif
      run(12, 1'b0, pm, qm);

      // Five clean presses into the downstream counter
      base      = pulse_total;
      press_cnt = 0;
      out_total = 0;
      for (int k = 0; k < 5; k++) begin
         run(12, 1'b1, pm, qm);
         run(12, 1'b0, pm, qm);
      end
      check("five_pulses", 32'(pulse_total - base), 32'd5);
      check("five_out", 32'(out_total), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/btn_pulse.md
BTN_PULSE -- requirements
Module: btn_pulse

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples required to accept a level change; legal range >= 1.
REQ-002 SHALL have parameter REPEAT_DELAY, default 500000: cycles from the first pulse of a hold to the first auto-repeat pulse; legal range >= 1.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 100000: cycles between subsequent auto-repeat pulses; legal range >= 1.
REQ-004 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port `btn_in`, input, 1 bit: raw asynchronous, bouncing push-button level (1 = pressed).
REQ-007 SHALL have port `pulse`, output, 1 bit: registered single-cycle press strobe; drives the downstream `w` input of the press-counting FSM.
REQ-008 SHALL have port `pressed`, output, 1 bit: registered debounced button level.

Function
REQ-009 SHALL pass `btn_in` through a 2-flop synchronizer; "sync" below means the second flop's output.
REQ-010 SHALL implement states IDLE, WAIT_HIGH, HELD and WAIT_LOW, with a debounce counter `dcnt` of width $clog2(DEBOUNCE_CYCLES)+1.
REQ-011 In IDLE, sync=1 SHALL move the FSM to WAIT_HIGH with dcnt=0; otherwise it SHALL stay in IDLE.
REQ-012 In WAIT_HIGH, sync=0 SHALL return the FSM to IDLE with no pulse.
REQ-013 In WAIT_HIGH with sync=1, dcnt==DEBOUNCE_CYCLES-1 SHALL move the FSM to HELD and assert `pulse` in the next cycle; otherwise dcnt SHALL increment.
REQ-014 In HELD, sync=0 SHALL move the FSM to WAIT_LOW with dcnt=0.
REQ-015 In WAIT_LOW, sync=1 SHALL return the FSM to HELD with no pulse and the repeat counter cleared.
REQ-016 In WAIT_LOW with sync=0, dcnt==DEBOUNCE_CYCLES-1 SHALL move the FSM to IDLE; otherwise dcnt SHALL increment.
REQ-017 `pressed` SHALL be 1 exactly while the FSM is in HELD or WAIT_LOW, registered.
REQ-018 `pulse` SHALL be high for exactly one cycle per accepted press and SHALL never be high on consecutive cycles.
REQ-019 Latency: counting the first rising edge that samples btn_in=1 as edge 1, `pulse` SHALL be high in the cycle following edge DEBOUNCE_CYCLES+3, provided btn_in stays 1 throughout.
REQ-020 A press shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no pulse and no change on `pressed`.

Reset
REQ-021 While `reset`=1 at a clock edge: state SHALL be IDLE, dcnt and repeat counter 0, synchronizer flops 0, `pulse`=0, `pressed`=0.
REQ-022 Reset asserted in any state, including mid-debounce, SHALL abort the operation without a pulse.
REQ-023 A button still held when reset deasserts SHALL be debounced anew and SHALL yield one pulse, per REQ-019 timing counted from the first non-reset edge.

Configuration
REQ-024 Macro BTN_PULSE_AUTOREPEAT_EN SHALL control auto-repeat as follows.
- Defined: in HELD with sync=1, the repeat counter SHALL count cycles since entry into HELD. An extra single-cycle `pulse` SHALL fire when the count reaches REPEAT_DELAY, and again every REPEAT_PERIOD cycles after that, until HELD is left.
- Undefined: the repeat logic SHALL be absent, REPEAT_DELAY and REPEAT_PERIOD SHALL be ignored, and at most one pulse SHALL occur per press.

Structure
REQ-025 State encodings (2-bit localparams) and a counter-width function SHALL live in shared package btn_pulse_pkg.
REQ-026 The synchronizer SHALL be a separate sub-module, sync_2ff (parameterless, reset to 0).

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
REQ-027 Clean press: btn_in 0->1, held 20 cycles, then released -> `pulse` high only in cycle 7 after the first sampling edge; `pressed` goes 1 then returns to 0 after release plus 7 cycles.
REQ-028 Bounce: btn_in 1,1,0,1 then held high -> exactly one pulse, 7 cycles after the last 0->1 edge.
REQ-029 Release glitch: in HELD, btn_in=0 for 2 cycles, then 1 -> `pressed` stays 1 and no pulse occurs.
REQ-030 Reset mid-WAIT_HIGH with btn_in held 1: reset asserted for 2 cycles -> no pulse during reset; one pulse 7 cycles after the first non-reset edge.
REQ-031 Auto-repeat, hold 30 cycles: with BTN_PULSE_AUTOREPEAT_EN defined -> pulses at cycles 7, 15, 18, 21, 24, 27, 30; undefined -> single pulse at cycle 7.
REQ-032 Five clean presses fed to the downstream press-counting FSM -> exactly five pulses, and exactly one downstream `out` strobe.
